// File: rtl/fifo_8bits_if.sv
// rtl/fifo_8bits_if.sv - byte FIFO push/pop handshake and status bundle
interface fifo_8bits_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;

  modport master (
    output data_in, push, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  data_in, push, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_8bits.sv
// rtl/fifo_8bits.sv - 8-entry byte FIFO behind the PCIe PHY 2:1 byte mux
// FIFO_ERR_STICKY_EN: error latches until reset instead of pulsing one cycle.
module fifo_8bits #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic         clk,
  input  logic         reset_L,
  fifo_8bits_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_C    = ALMOST_FULL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AE_C    = ALMOST_EMPTY[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  full, empty, wr_en, rd_en, err_ev;

  always_comb begin
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    // A pop on a full FIFO frees the slot the same edge, so the push is kept.
    wr_en   = bus.push && (!full || bus.pop);
    rd_en   = bus.pop && !empty;
    err_ev  = (bus.push && full && !bus.pop) || (bus.pop && empty);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    error_d = error_q | err_ev;
`else
    error_d = err_ev;
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.error        = error_q;
endmodule

// File: tb/tb_fifo_8bits.sv
// tb/tb_fifo_8bits.sv - directed table plus randomized model check of fifo_8bits
module tb_fifo_8bits;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  fifo_8bits_if #(.DATA_WIDTH(8)) bus ();

  fifo_8bits #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .ALMOST_FULL(6), .ALMOST_EMPTY(2)
  ) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       valid, full, empty, af, ae, err;
  } vec_t;

  vec_t tbl[24];
  int   nvec = 0;
  int   nerr = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_valid, m_err;

  function automatic logic [13:0] actual();
    return {bus.data_out, bus.valid_out, bus.full, bus.empty,
            bus.almost_full, bus.almost_empty, bus.error};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = actual();
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got {dout,v,f,e,af,ae,err}=%h/%b required %h/%b",
               name, act[13:6], act[5:0], exp[13:6], exp[5:0]);
    end
  endtask

  task automatic drive(input logic p, input logic o, input logic [7:0] d);
    bus.push = p; bus.pop = o; bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    mq.delete();
    m_dout = 8'h00; m_valid = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(input logic p, input logic o, input logic [7:0] d);
    int  n;
    logic ev;
    n  = mq.size();
    ev = (p && n == 8 && !o) || (o && n == 0);
    if (o && n > 0) begin
      m_dout  = mq.pop_front();
      m_valid = 1'b1;
    end else m_valid = 1'b0;
    if (p && (n < 8 || o)) mq.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
    m_err = m_err | ev;
`else
    m_err = ev;
`endif
  endfunction

  function automatic logic [13:0] model_exp();
    int n;
    n = mq.size();
    return {m_dout, m_valid, n == 8, n == 0, n >= 6, n <= 2, m_err};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 8'h00;
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
  endtask

  initial begin
    logic sticky_err;
    logic p, o;
    logic [7:0] d;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 8'h00;

    //           push pop din    dout  v  f  e  af ae err
    tbl[0]  = '{0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0};
    tbl[1]  = '{1, 0, 8'hA0, 8'h00, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 8'hA1, 8'h00, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 8'hA2, 8'h00, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 8'hA3, 8'h00, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 8'hA4, 8'h00, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 8'hA5, 8'h00, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{1, 0, 8'hA6, 8'h00, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{1, 0, 8'hA7, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 8'hFF, 8'h00, 0, 1, 0, 1, 0, 1};
    tbl[10] = '{0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[11] = '{1, 1, 8'h55, 8'hA0, 1, 1, 0, 1, 0, 0};
    tbl[12] = '{0, 1, 8'h00, 8'hA1, 1, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 1, 8'h00, 8'hA2, 1, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 1, 8'h00, 8'hA3, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 8'h00, 8'hA4, 1, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 8'h00, 8'hA5, 1, 0, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 8'h00, 8'hA6, 1, 0, 0, 0, 1, 0};
    tbl[18] = '{0, 1, 8'h00, 8'hA7, 1, 0, 0, 0, 1, 0};
    tbl[19] = '{0, 1, 8'h00, 8'h55, 1, 0, 1, 0, 1, 0};
    tbl[20] = '{1, 1, 8'h66, 8'h55, 0, 0, 0, 0, 1, 1};
    tbl[21] = '{0, 1, 8'h00, 8'h66, 1, 0, 1, 0, 1, 0};
    tbl[22] = '{0, 1, 8'h00, 8'h66, 0, 0, 1, 0, 1, 1};
    tbl[23] = '{0, 0, 8'h00, 8'h66, 0, 0, 1, 0, 1, 0};

    do_reset();
    #1;
    check("reset_state", {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});

    sticky_err = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].push, tbl[i].pop, tbl[i].din);
`ifdef FIFO_ERR_STICKY_EN
      sticky_err = sticky_err | tbl[i].err;
`else
      sticky_err = tbl[i].err;
`endif
      check($sformatf("table[%0d]", i),
            {tbl[i].dout, tbl[i].valid, tbl[i].full, tbl[i].empty,
             tbl[i].af, tbl[i].ae, sticky_err});
      @(negedge clk);
    end

    // Async reset while holding four bytes, observed with clk held low.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = 8'hC0 + 8'(i);
      drive(1'b1, 1'b0, d);
      model_step(1'b1, 1'b0, d);
      check($sformatf("pre_reset_push[%0d]", i), model_exp());
      @(negedge clk);
    end
    bus.push = 1'b0; bus.pop = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    check("async_reset_no_edge", {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, 8'h00);
    model_step(1'b0, 1'b1, 8'h00);
    check("pop_after_reset", model_exp());
    @(negedge clk);

    // Randomized traffic in phases biased toward filling, mixing and draining.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ((i / 50) % 3)
        0:       begin p = ($urandom_range(0, 3) != 0); o = ($urandom_range(0, 3) == 0); end
        1:       begin p = $urandom_range(0, 1) == 1;   o = $urandom_range(0, 1) == 1;   end
        default: begin p = ($urandom_range(0, 3) == 0); o = ($urandom_range(0, 3) != 0); end
      endcase
      d = 8'($urandom);
      drive(p, o, d);
      model_step(p, o, d);
      check($sformatf("random[%0d]", i), model_exp());
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_8bits.md
# fifo_8bits

Eight-bit synchronous FIFO directly downstream of the 2:1 byte multiplexer in the PCIe physical-layer datapath. It captures every valid byte the mux presents (`data_in` qualified by `push`, wired to the mux `outValid`). It buffers up to `DEPTH` bytes and delivers them in order to the next stage on request (`pop`). It reports occupancy flags so the upstream and downstream stages can throttle, and it flags overflow/underflow.

## Interface
- `DATA_WIDTH`, 8, width of each stored word
- `ADDR_WIDTH`, 3, pointer width; `DEPTH = 2**ADDR_WIDTH` (8 entries)
- `ALMOST_FULL`, 6, `almost_full` asserted when count >= this value
- `ALMOST_EMPTY`, 2, `almost_empty` asserted when count <= this value
- `clk`  input  1  single clock; all state updates on rising edge
- `reset_L`  input  1  asynchronous, active-low reset
- `data_in`  input  DATA_WIDTH  byte from mux output
- `push`  input  1  write strobe (mux `outValid`)
- `pop`  input  1  read request from downstream stage
- `data_out`  output  DATA_WIDTH  registered read data
- `valid_out`  output  1  `data_out` holds a byte popped on the previous edge
- `full`  output  1  count == DEPTH
- `empty`  output  1  count == 0
- `almost_full`  output  1  count >= ALMOST_FULL
- `almost_empty`  output  1  count <= ALMOST_EMPTY
- `error`  output  1  overflow or underflow indication (see Configuration)

## Operation
- State: memory `DEPTH x DATA_WIDTH`, `wr_ptr` and `rd_ptr` (ADDR_WIDTH bits), and `count` (ADDR_WIDTH+1 bits, range 0..DEPTH).
- Reset (`reset_L` low, asynchronous):
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `data_out` = 0, `valid_out` = 0, `error` = 0.
  - Flags evaluate from count 0: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data immediately.
- Write: `push && (!full || pop)`. Memory[`wr_ptr`] <= `data_in`, and `wr_ptr` increments, wrapping at DEPTH naturally.
- Read: `pop && !empty`. `data_out` <= memory[`rd_ptr`], `valid_out` <= 1, and `rd_ptr` increments with wrap.
- With no valid read in a cycle, `valid_out` <= 0 and `data_out` holds its last value.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither occur.
- Simultaneous push and pop:
  - When full, both happen and count stays at DEPTH.
  - When empty, only the write happens; there is no bypass, so count becomes 1 and `valid_out` = 0.
- Overflow: `push && full && !pop`. The byte is dropped, pointers and count are unchanged, and an error event is raised.
- Underflow: `pop && empty`. The request is ignored, `valid_out` <= 0, and an error event is raised.
- Flags are combinational decodes of the registered `count`. They reflect occupancy after the most recent edge.

## Timing
- Write-to-readable latency: 1 cycle. A byte pushed at edge N can be popped at edge N+1.
- Read latency: 1 cycle. `pop` sampled at edge N gives `data_out`/`valid_out` valid after edge N, for the whole cycle N..N+1.
- Sustained throughput is 1 byte/cycle in and 1 byte/cycle out.
- `error` updates on the same edge that samples the offending request.

## Configuration
- Macro `FIFO_ERR_STICKY_EN`.
- Defined: `error` is sticky. It sets on the first overflow/underflow and stays 1 until `reset_L` is asserted.
- Not defined: `error` is a one-cycle pulse, 1 only in the cycle after an overflow/underflow edge and 0 otherwise.
- Data path and flags are identical in both builds.

## Test plan
- Reset then idle: `reset_L`=0 then 1 with `push`=`pop`=0 -> `empty`=1, `almost_empty`=1, `full`=0, `valid_out`=0, `data_out`=8'h00, `error`=0.
- Fill: push 8'hA0..8'hA7 on 8 consecutive edges -> `almost_empty` drops after the 3rd push, `almost_full`=1 after the 6th, `full`=1 after the 8th, `empty`=0 from the 1st.
- Overflow: on a full FIFO push 8'hFF with `pop`=0 -> contents unchanged and `error`=1. The error stays 1 with `FIFO_ERR_STICKY_EN` and is a one-cycle pulse without it.
- Drain with wrap: pop 8 times after the fill -> `data_out` sequence A0..A7 with `valid_out`=1 each cycle, then `empty`=1. A further push 8'h11 / pop returns 8'h11 with the pointers wrapped.
- Simultaneous push/pop: push 8'h55 and pop together on a full FIFO -> oldest byte is output, count stays 8, `full`=1, no error. Push 8'h66 and pop together on an empty FIFO -> `valid_out`=0, `error`=1 (underflow), count 1, next pop returns 8'h66.
- Async reset mid-stream: assert `reset_L` low between edges while holding 4 bytes -> outputs go to reset values immediately without a clock edge. After release, a pop returns nothing (`valid_out`=0).
